// File: rtl/bitplane_fetch_if.sv
// Load-handshake and memory-read bundle between the LED sequencer side and bitplane_fetch.
// Signals: load_rq/plane/address in, data_ready/data_out/busy back;
//          mem_rd/mem_addr out to frame memory, mem_rdata back from it.
// plane carries the bit-plane index (the requester's "bit" field).
interface bitplane_fetch_if #(
    parameter int ADDR_W   = 11,
    parameter int NUM_LEDS = 8,
    parameter int BIT_W    = 4
);
    logic                load_rq;
    logic [BIT_W-1:0]    plane;
    logic [ADDR_W-1:0]   address;
    logic                data_ready;
    logic [NUM_LEDS-1:0] data_out;
    logic                busy;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rdata;

    // master: the sequencer plus the frame memory it sits beside
    modport master (
        output load_rq, plane, address, mem_rdata,
        input  data_ready, data_out, busy, mem_rd, mem_addr
    );

    // slave: the fetch engine
    modport slave (
        input  load_rq, plane, address, mem_rdata,
        output data_ready, data_out, busy, mem_rd, mem_addr
    );
endinterface

// File: rtl/bitplane_fetch.sv
// Fetches NUM_LEDS bytes from frame memory and packs one bit plane into an LED-wide word.
// Latency: data_ready at NUM_LEDS+MEM_LAT+1 clocks after the synchronized request rises.
// Backpressure: none on memory; 4-phase handshake, data_ready drops one clock after req_s falls.
// Ports: clock, rst_n (async active-low), bus (slave modport of bitplane_fetch_if).
module bitplane_fetch #(
    parameter int ADDR_W      = 11,
    parameter int NUM_LEDS    = 8,
    parameter int BIT_W       = 4,
    parameter int MEM_LAT     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clock,
    input  logic           rst_n,
    bitplane_fetch_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_LEDS + 1);
    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_LEDS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   req_s, req_s_d, armed;
    logic                   start, abort, finish;

    logic [BIT_W-1:0]    bit_c;
    logic [ADDR_W-1:0]   base_c;
    logic [CNT_W-1:0]    issue_cnt, ret_cnt;
    logic [NUM_LEDS-1:0] shadow, shadow_nxt, data_out_q;
    logic [MEM_LAT-1:0]  vld_pipe;
    logic                ret_vld, ret_bit, accept, fill_done;

    assign req_s = sync_q[SYNC_STAGES-1];

    // warm_q marks when the synchronizer holds real samples; a request that
    // was already high at reset release must be seen low before it can arm.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            warm_q  <= '0;
            req_s_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.load_rq};
            warm_q  <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            req_s_d <= req_s;
            if (warm_q[SYNC_STAGES-1] && !req_s) armed <= 1'b1;
        end
    end

    assign start     = (state_q == IDLE) && armed && req_s && !req_s_d;
    assign ret_vld   = vld_pipe[MEM_LAT-1];
    assign ret_bit   = (32'(bit_c) < 32'd8) ? bus.mem_rdata[bit_c[2:0]] : 1'b0;
    assign accept    = ret_vld && (state_q == ISSUE || state_q == DRAIN) && !abort;
    // Look ahead by one return so the word is ready the cycle after the last byte lands.
    assign fill_done = (ret_cnt == FULL) || (ret_vld && ret_cnt == LAST);

    always_comb begin
        shadow_nxt = shadow;
        if (accept && ret_cnt < FULL) shadow_nxt[ret_cnt[IDX_W-1:0]] = ret_bit;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                if (!req_s) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (issue_cnt == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!req_s) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (fill_done) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:  if (!req_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bit_c      <= '0;
            base_c     <= '0;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            shadow     <= '0;
            data_out_q <= '0;
            vld_pipe   <= '0;
        end else begin
            if (start) begin
                bit_c     <= bus.plane;
                base_c    <= bus.address;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                shadow    <= '0;
            end else begin
                if (state_q == ISSUE) issue_cnt <= issue_cnt + 1'b1;
                if (accept) begin
                    shadow  <= shadow_nxt;
                    ret_cnt <= ret_cnt + 1'b1;
                end
            end
            // An abort flushes everything still in flight.
            if (abort) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= (state_q == ISSUE);
                for (int i = 1; i < MEM_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            end
            if (finish) data_out_q <= shadow_nxt;
        end
    end

    assign bus.mem_rd     = (state_q == ISSUE);
    assign bus.mem_addr   = (state_q == ISSUE) ? base_c + ADDR_W'(issue_cnt) : '0;
    assign bus.busy       = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.data_ready = (state_q == DONE);
    assign bus.data_out   = data_out_q;
endmodule

// File: tb/tb_bitplane_fetch.sv
// Bench for bitplane_fetch: three instances with MEM_LAT 1..3 sharing one frame memory image.
// Expected words and read addresses go into queues as requests are driven and are
// popped when the DUT presents them.
module tb_bitplane_fetch;
    localparam int AW = 11;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]         load_rq;
    logic [2:0][3:0]    plane;
    logic [2:0][AW-1:0] address;
    wire  [2:0]         rdy, mem_rd, busy;
    wire  [2:0][7:0]    dout;
    wire  [2:0][AW-1:0] maddr;

    logic [7:0]    mem [2048];
    int            total = 0;
    int            bad = 0;
    bit            addr_chk = 1'b0;
    logic [AW-1:0] addr_q[$];
    logic [7:0]    exp_q[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bitplane_fetch_if #(.ADDR_W(AW), .NUM_LEDS(8), .BIT_W(4)) ifc ();
        logic [7:0] pipe [3];

        assign ifc.load_rq   = load_rq[g];
        assign ifc.plane     = plane[g];
        assign ifc.address   = address[g];
        assign ifc.mem_rdata = pipe[g];
        assign rdy[g]        = ifc.data_ready;
        assign mem_rd[g]     = ifc.mem_rd;
        assign busy[g]       = ifc.busy;
        assign dout[g]       = ifc.data_out;
        assign maddr[g]      = ifc.mem_addr;

        // Memory with g+1 cycles of read latency; junk when no read was issued.
        always @(posedge clock) begin
            pipe[0] <= ifc.mem_rd ? mem[ifc.mem_addr] : 8'($urandom);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        bitplane_fetch #(
            .ADDR_W(AW), .NUM_LEDS(8), .BIT_W(4), .MEM_LAT(g + 1), .SYNC_STAGES(2)
        ) dut (
            .clock (clock),
            .rst_n (rst_n),
            .bus   (ifc)
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] plane_of(input logic [AW-1:0] a, input logic [3:0] b);
        logic [7:0] w;
        logic [7:0] by;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            by   = mem[a + AW'(i)];
            w[i] = (b < 4'd8) ? by[b[2:0]] : 1'b0;
        end
        return w;
    endfunction

    // Read-address scoreboard for instance 0.
    always @(negedge clock) begin
        if (addr_chk && mem_rd[0]) begin
            if (addr_q.size() == 0) check("unexpected_rd", 32'(maddr[0]), 32'hFFFF);
            else                    check("rd_addr", 32'(maddr[0]), 32'(addr_q.pop_front()));
        end
    end

    // One full 4-phase transaction; expected latency is SYNC(2) + NUM_LEDS+1 + MEM_LAT.
    task automatic do_req(input int inst, input logic [AW-1:0] a, input logic [3:0] b,
                          input logic [7:0] expw);
        int k, first_rd, nrd;
        logic [7:0] w;
        plane[inst]   = b;
        address[inst] = a;
        load_rq[inst] = 1'b1;
        exp_q.push_back(expw);
        if (inst == 0) for (int i = 0; i < 8; i++) addr_q.push_back(a + AW'(i));
        k = 0; first_rd = -1; nrd = 0;
        while (!rdy[inst] && k < 60) begin
            @(negedge clock);
            k++;
            if (mem_rd[inst]) begin
                nrd++;
                if (first_rd < 0) first_rd = k;
            end
            // Captured long ago; scrambling must not disturb the fetch.
            if (k == 4) begin
                plane[inst]   = ~b;
                address[inst] = ~a;
            end
        end
        check("ready_latency", k, 12 + inst);
        check("first_rd", first_rd, 3);
        check("rd_count", nrd, 8);
        check("busy_at_ready", busy[inst], 1'b0);
        w = exp_q.pop_front();
        check("data_out", dout[inst], w);
        load_rq[inst] = 1'b0;
        k = 0;
        while (rdy[inst] && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("ready_fall", k, 3);
        check("data_out_hold", dout[inst], w);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nrd, nrdy;
        logic [7:0] a5;
        load_rq = '1;
        plane   = '0;
        address = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i * 17);

        // Reset with load_rq already high.
        repeat (3) @(negedge clock);
        check("rst_ready", rdy[0], 1'b0);
        check("rst_data_out", dout[0], 8'h00);
        check("rst_mem_rd", mem_rd[0], 1'b0);
        check("rst_mem_addr", maddr[0], 11'h000);
        check("rst_busy", busy[0], 1'b0);
        rst_n    = 1'b1;
        addr_chk = 1'b1;
        repeat (20) @(negedge clock);
        check("no_start_after_rst", busy, 3'b000);
        check("no_ready_after_rst", rdy, 3'b000);
        load_rq = '0;
        repeat (4) @(negedge clock);

        // Basic fetch: bytes 0x10,0x21,...,0x87, plane 4.
        do_req(0, 11'h010, 4'd4, 8'h55);

        // Wrap: odd bytes at 7FC/7FE/000/002.
        mem[11'h7FC] = 8'h01; mem[11'h7FD] = 8'h02; mem[11'h7FE] = 8'h03; mem[11'h7FF] = 8'h04;
        mem[11'h000] = 8'h05; mem[11'h001] = 8'h06; mem[11'h002] = 8'h07; mem[11'h003] = 8'h08;
        do_req(0, 11'h7FC, 4'd0, 8'h55);

        // Out-of-range plane on all-ones memory.
        for (int i = 0; i < 2048; i++) mem[i] = 8'hFF;
        do_req(0, 11'h400, 4'd9, 8'h00);

        // Prior fetch leaves 0xA5, then an aborted request.
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) mem[11'h100 + i] = {7'($urandom), a5[i]};
        do_req(0, 11'h100, 4'd0, 8'hA5);
        addr_chk   = 1'b0;
        plane[0]   = 4'd3;
        address[0] = 11'h200;
        load_rq[0] = 1'b1;
        k = 0;
        while (!mem_rd[0] && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("abort_first_rd", k, 3);
        repeat (2) @(negedge clock);
        load_rq[0] = 1'b0;
        nrd = 0; nrdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (mem_rd[0]) nrd++;
            if (rdy[0])    nrdy++;
        end
        check("abort_rd_tail", nrd, 2);
        check("abort_no_ready", nrdy, 0);
        check("abort_data_out", dout[0], 8'hA5);
        check("abort_busy", busy[0], 1'b0);
        addr_q.delete();
        addr_chk = 1'b1;
        do_req(0, 11'h200, 4'd3, plane_of(11'h200, 4'd3));

        // Async reset in the middle of a fetch, request held high through it.
        addr_chk   = 1'b0;
        address[0] = 11'h300;
        load_rq[0] = 1'b1;
        repeat (6) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_rd", mem_rd[0], 1'b0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_data_out", dout[0], 8'h00);
        @(negedge clock);
        rst_n = 1'b1;
        addr_q.delete();
        addr_chk = 1'b1;
        repeat (20) @(negedge clock);
        check("midrst_no_restart", busy[0], 1'b0);
        load_rq[0] = 1'b0;
        repeat (4) @(negedge clock);

        // Latency sweep: 16 back-to-back requests per instance, crossing the wrap.
        for (int inst = 0; inst < 3; inst++) begin
            for (int n = 0; n < 16; n++) begin
                logic [AW-1:0] a;
                logic [3:0]    b;
                a = 11'h7C0 + AW'(8 * n);
                b = 4'(n % 8);
                do_req(inst, a, b, plane_of(a, b));
            end
        end

        check("addr_q_empty", addr_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
